// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words, writes them to IMEM and holds the core in reset until done.
// Optional checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_reset_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_e;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_END = S_CHK;
`else
  localparam state_e S_END = S_DONE;
`endif

  state_e              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         shreg_q, shreg_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic        xfer;
  logic [15:0] len_n;

  assign xfer  = in_valid_i && ready_q;
  assign len_n = {len_hi_q, in_data_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_LEN_HI;
      len_hi_q   <= '0;
      last_q     <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    last_d   = last_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    if (xfer && (state_q == S_LEN_HI || state_q == S_LEN_LO || state_q == S_DATA)) begin
      sum_d = sum_q + in_data_i;
    end
`endif

    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data_i;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          idx_d  = '0;
          bcnt_d = '0;
          last_d = ADDR_W'(len_n - 16'd1);
          if ({1'b0, len_n} > CAP) begin
            state_d = S_ERR;
          end else if (len_n == 16'd0) begin
            state_d = S_END;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          bcnt_d  = bcnt_q + 2'd1;
          shreg_d = {shreg_q[15:0], in_data_i};
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = {shreg_q, in_data_i};
            // last_q = N-1 always fits because N never exceeds capacity here
            if (idx_q == last_q) begin
              state_d = S_END;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer) begin
          state_d = ((sum_q + in_data_i) == 8'd0) ? S_DONE : S_ERR;
        end
`endif
      end
      default: ;
    endcase

    ready_d    = (state_d != S_DONE) && (state_d != S_ERR);
    // Status lags the state by one edge so the final IMEM write lands before the core fetches.
    core_rst_d = (state_q != S_DONE);
    done_d     = (state_q == S_DONE);
    err_d      = (state_q == S_ERR);
  end

  assign in_ready_o   = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_reset_o = core_rst_q;
  assign done_o       = done_q;
  assign error_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard; checksum cases follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  int total = 0;
  int bad = 0;
  logic [7:0] csum = 8'h00;
  logic [ADDR_W+31:0] exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .core_reset_o (core_reset),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  // Every write pulse must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        assert (imem_we === 1'b0) else begin
          bad++;
          $error("FAIL unexpected_write got addr=%0h data=%0h exp no write", imem_addr, imem_wdata);
        end
      end else begin
        logic [ADDR_W+31:0] want;
        want = exp_q.pop_front();
        assert ({imem_addr, imem_wdata} === want) else begin
          bad++;
          $error("FAIL write got=%0h exp=%0h", {imem_addr, imem_wdata}, want);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_vals);
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    csum = 8'h00;
    tick();
    tick();
    if (check_vals) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
    end
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      chk("ready_timeout", in_ready, 1);
    end else begin
      tick();
      csum = csum + b;
    end
  endtask

  task automatic send_trailer(input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 - csum, gap);
`endif
    in_valid = 1'b0;
  endtask

  task automatic finish_ok(input string tag);
    chk({tag, "_done_lag"}, done, 0);
    chk({tag, "_core_reset_lag"}, core_reset, 1);
    chk({tag, "_in_ready_off"}, in_ready, 0);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_core_reset"}, core_reset, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic send_stream(input logic [7:0] bytes[], input bit gaps);
    foreach (bytes[i]) send_byte(bytes[i], gaps ? int'($urandom_range(1, 3)) : 0);
  endtask

  initial begin
    logic [7:0] two[];
    logic [7:0] part[];
    logic [7:0] one[];
    two  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    part = '{8'h00, 8'h01, 8'hCA, 8'hFE};
    one  = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};

    do_reset(1'b1);

    // Back-to-back two-word load
    exp_q.push_back({8'd0, 32'h12345678});
    exp_q.push_back({8'd1, 32'hDEADBEEF});
    send_stream(two, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("two_last_we", imem_we, 1);
`endif
    send_trailer(0);
    finish_ok("two");
    chk("two_hold_addr", imem_addr, 1);
    chk("two_hold_wdata", imem_wdata, 32'hDEADBEEF);
    chk("two_sb_empty", exp_q.size(), 0);

    // Same stream with random valid gaps
    do_reset(1'b1);
    exp_q.push_back({8'd0, 32'h12345678});
    exp_q.push_back({8'd1, 32'hDEADBEEF});
    send_stream(two, 1'b1);
    send_trailer(2);
    finish_ok("gap");
    repeat (3) tick();
    chk("gap_sb_empty", exp_q.size(), 0);

    // Zero length: no writes
    do_reset(1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_trailer(0);
    finish_ok("zero");

    // Oversize length 257
    do_reset(1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    in_valid = 1'b0;
    chk("big_in_ready", in_ready, 0);
    chk("big_error_lag", error, 0);
    tick();
    chk("big_error", error, 1);
    chk("big_core_reset", core_reset, 1);
    chk("big_done", done, 0);
    repeat (3) tick();
    chk("big_error_sticky", error, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good and bad checksum on 00 01 AA BB CC DD
    do_reset(1'b0);
    exp_q.push_back({8'd0, 32'hAABBCCDD});
    send_stream('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
    send_byte(8'hF1, 0);
    in_valid = 1'b0;
    finish_ok("chk_good");

    do_reset(1'b0);
    exp_q.push_back({8'd0, 32'hAABBCCDD});
    send_stream('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
    send_byte(8'hF0, 0);
    in_valid = 1'b0;
    chk("chk_bad_in_ready", in_ready, 0);
    tick();
    chk("chk_bad_error", error, 1);
    chk("chk_bad_core_reset", core_reset, 1);
    chk("chk_bad_done", done, 0);
`endif

    // Reset in the middle of word 0, then a clean single-word load
    do_reset(1'b0);
    send_stream(part, 1'b0);
    in_valid = 1'b0;
    do_reset(1'b1);
    exp_q.push_back({8'd0, 32'hCAFEF00D});
    send_stream(one, 1'b0);
    send_trailer(0);
    finish_ok("midrst");
    repeat (3) tick();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
